// File: rtl/accel_seq_pkg.sv
// Shared definitions for the ADXL345 poll sequencer.
// Holds the sequencer state encoding, the accelerometer register map used by the
// sequencer, the configuration values written after reset and the expected DEVID.
// Optional feature macro: ACCEL_SEQ_DEVID_CHECK_EN adds the DEVID check states.
package accel_seq_pkg;

  typedef enum logic [3:0] {
    CFG_ISSUE,
    CFG_WAIT,
    POLL_IDLE,
    RD_ISSUE,
    RD_WAIT,
    PUBLISH
`ifdef ACCEL_SEQ_DEVID_CHECK_EN
    ,
    ID_ISSUE,
    ID_WAIT,
    CFG_ERR
`endif
  } seq_state_t;

`ifdef ACCEL_SEQ_DEVID_CHECK_EN
  localparam seq_state_t RESET_STATE = ID_ISSUE;
`else
  localparam seq_state_t RESET_STATE = CFG_ISSUE;
`endif

  localparam logic [7:0] REG_DEVID       = 8'h00;
  localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
  localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
  localparam logic [7:0] REG_DATAX0      = 8'h32;

  localparam logic [7:0] CFG_DATA_FORMAT = 8'h08;  // full resolution, +/-2 g
  localparam logic [7:0] CFG_POWER_CTL   = 8'h08;  // measure mode
  localparam logic [7:0] DEVID_VALUE     = 8'hE5;

  localparam logic [2:0] LAST_BYTE = 3'd5;

  // Configuration step k: 0 -> DATA_FORMAT, 1 -> POWER_CTL.
  function automatic logic [7:0] cfg_reg(input logic k);
    return k ? REG_POWER_CTL : REG_DATA_FORMAT;
  endfunction

  function automatic logic [7:0] cfg_val(input logic k);
    return k ? CFG_POWER_CTL : CFG_DATA_FORMAT;
  endfunction

endpackage

// File: rtl/accel_poll_sequencer_poll_tick_gen.sv
// poll_tick_gen: free-running poll-period timer.
// Counts 0..POLL_CYCLES-1 while enable is high and wraps; tick is high for the
// single cycle in which the counter sits at its last value (the wrap cycle).
// Ports: clk, rst (sync, active high), enable, tick.
module poll_tick_gen #(
  parameter int unsigned POLL_CYCLES = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(POLL_CYCLES - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/accel_poll_sequencer.sv
// accel_poll_sequencer: owns the single-register I2C controller and drives the
// ADXL345. After reset it writes DATA_FORMAT then POWER_CTL, then reads the six
// data registers every POLL_CYCLES cycles and publishes signed X/Y/Z samples.
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   i2c_dev_addr/reg_addr/r_w/write_data/start   request to the controller
//   i2c_ready/finished/read_data                 response from the controller
//   accel_x/y/z, sample_valid                    published sample set
//   cfg_done, overrun, busy, devid_err           status
// Optional feature macro: ACCEL_SEQ_DEVID_CHECK_EN (DEVID read before configuring;
// devid_err is tied low when undefined).
module accel_poll_sequencer
  import accel_seq_pkg::*;
#(
  parameter int         SYS_CLK_SPEED = 50000000,
  parameter int         POLL_HZ       = 100,
  parameter logic [6:0] DEV_ADDR      = 7'h1D
) (
  input  logic        clk,
  input  logic        rst,
  output logic [6:0]  i2c_dev_addr,
  output logic [7:0]  i2c_reg_addr,
  output logic        i2c_r_w,
  output logic [7:0]  i2c_write_data,
  output logic        i2c_start,
  input  logic        i2c_ready,
  input  logic        i2c_finished,
  input  logic [7:0]  i2c_read_data,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        sample_valid,
  output logic        cfg_done,
  output logic        overrun,
  output logic        busy,
  output logic        devid_err
);

  localparam int unsigned POLL_CYCLES = SYS_CLK_SPEED / POLL_HZ;

  seq_state_t  state, state_d;
  logic        k, k_d;
  logic [2:0]  n, n_d;
  logic        pending, tick;
  logic [47:0] shadow;
  logic        start_d, req_load, req_rw_d, capture, publish;
  logic        set_cfg_done, clr_pending, set_devid_err;
  logic [7:0]  req_addr_d, req_data_d;

  poll_tick_gen #(.POLL_CYCLES(POLL_CYCLES)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (cfg_done),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= RESET_STATE;
    else     state <= state_d;
  end

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state;
    k_d           = k;
    n_d           = n;
    start_d       = 1'b0;
    req_load      = 1'b0;
    req_addr_d    = 8'h00;
    req_rw_d      = 1'b0;
    req_data_d    = 8'h00;
    capture       = 1'b0;
    publish       = 1'b0;
    set_cfg_done  = 1'b0;
    clr_pending   = 1'b0;
    set_devid_err = 1'b0;
    case (state)
`ifdef ACCEL_SEQ_DEVID_CHECK_EN
      ID_ISSUE: if (i2c_ready) begin
        start_d    = 1'b1;
        req_load   = 1'b1;
        req_addr_d = REG_DEVID;
        req_rw_d   = 1'b1;
        state_d    = ID_WAIT;
      end
      ID_WAIT: if (i2c_finished) begin
        if (i2c_read_data == DEVID_VALUE) begin
          state_d = CFG_ISSUE;
        end else begin
          set_devid_err = 1'b1;
          state_d       = CFG_ERR;
        end
      end
      CFG_ERR: state_d = CFG_ERR;
`endif
      CFG_ISSUE: if (i2c_ready) begin
        start_d    = 1'b1;
        req_load   = 1'b1;
        req_addr_d = cfg_reg(k);
        req_data_d = cfg_val(k);
        state_d    = CFG_WAIT;
      end
      CFG_WAIT: if (i2c_finished) begin
        if (k) begin
          set_cfg_done = 1'b1;
          state_d      = POLL_IDLE;
        end else begin
          k_d     = 1'b1;
          state_d = CFG_ISSUE;
        end
      end
      POLL_IDLE: if (pending) begin
        clr_pending = 1'b1;
        n_d         = 3'd0;
        state_d     = RD_ISSUE;
      end
      RD_ISSUE: if (i2c_ready) begin
        start_d    = 1'b1;
        req_load   = 1'b1;
        req_addr_d = REG_DATAX0 + {5'd0, n};
        req_rw_d   = 1'b1;
        state_d    = RD_WAIT;
      end
      RD_WAIT: if (i2c_finished) begin
        capture = 1'b1;
        if (n == LAST_BYTE) begin
          publish = 1'b1;
          state_d = PUBLISH;
        end else begin
          n_d     = n + 3'd1;
          state_d = RD_ISSUE;
        end
      end
      PUBLISH: state_d = POLL_IDLE;
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k              <= 1'b0;
      n              <= 3'd0;
      i2c_start      <= 1'b0;
      i2c_reg_addr   <= 8'h00;
      i2c_r_w        <= 1'b0;
      i2c_write_data <= 8'h00;
      // NOTE: the shadow bytes are reset on purpose: an interrupted read set
      // must never leak stale bytes into a later publish.
      shadow         <= '0;
      accel_x        <= 16'h0000;
      accel_y        <= 16'h0000;
      accel_z        <= 16'h0000;
      cfg_done       <= 1'b0;
      pending        <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      k         <= k_d;
      n         <= n_d;
      i2c_start <= start_d;
      // Request fields are loaded only on issue, so they hold until finished.
      if (req_load) begin
        i2c_reg_addr   <= req_addr_d;
        i2c_r_w        <= req_rw_d;
        i2c_write_data <= req_data_d;
      end
      if (capture) shadow[{n, 3'b000} +: 8] <= i2c_read_data;
      // The sixth byte bypasses its shadow so the new set appears in the
      // PUBLISH cycle, together with sample_valid.
      if (publish) begin
        accel_x <= {shadow[15:8],  shadow[7:0]};
        accel_y <= {shadow[31:24], shadow[23:16]};
        accel_z <= {i2c_read_data, shadow[39:32]};
      end
      if (set_cfg_done) cfg_done <= 1'b1;
      // A tick wins over a same-cycle clear, so that tick is never lost.
      if (set_cfg_done || tick) pending <= 1'b1;
      else if (clr_pending)     pending <= 1'b0;
      if (tick && pending) overrun <= 1'b1;
    end
  end

`ifdef ACCEL_SEQ_DEVID_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)                devid_err <= 1'b0;
    else if (set_devid_err) devid_err <= 1'b1;
  end
`else
  assign devid_err = 1'b0;
`endif

  assign i2c_dev_addr = DEV_ADDR;
  assign sample_valid = (state == PUBLISH);
  assign busy         = (state == CFG_WAIT) || (state == RD_WAIT)
`ifdef ACCEL_SEQ_DEVID_CHECK_EN
                        || (state == ID_WAIT)
`endif
                        ;

endmodule

// File: tb/tb_accel_poll_sequencer.sv
// Self-checking bench for accel_poll_sequencer: a bus-model I2C slave plus a
// transaction-level model of the expected register program and sample values.
module tb_accel_poll_sequencer;

  localparam int P = 500;
`ifdef ACCEL_SEQ_DEVID_CHECK_EN
  localparam int CFG_BASE = 1;
`else
  localparam int CFG_BASE = 0;
`endif

  typedef struct packed {
    logic [7:0] addr;
    logic       rw;
    logic [7:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  i2c_dev_addr;
  logic [7:0]  i2c_reg_addr;
  logic        i2c_r_w;
  logic [7:0]  i2c_write_data;
  logic        i2c_start;
  logic        i2c_ready = 1'b1;
  logic        i2c_finished = 1'b0;
  logic [7:0]  i2c_read_data = 8'h00;
  logic [15:0] accel_x, accel_y, accel_z;
  logic        sample_valid, cfg_done, overrun, busy, devid_err;

  always #5 clk = ~clk;

  accel_poll_sequencer #(
    .SYS_CLK_SPEED (50000),
    .POLL_HZ       (100),
    .DEV_ADDR      (7'h1D)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i2c_dev_addr   (i2c_dev_addr),
    .i2c_reg_addr   (i2c_reg_addr),
    .i2c_r_w        (i2c_r_w),
    .i2c_write_data (i2c_write_data),
    .i2c_start      (i2c_start),
    .i2c_ready      (i2c_ready),
    .i2c_finished   (i2c_finished),
    .i2c_read_data  (i2c_read_data),
    .accel_x        (accel_x),
    .accel_y        (accel_y),
    .accel_z        (accel_z),
    .sample_valid   (sample_valid),
    .cfg_done       (cfg_done),
    .overrun        (overrun),
    .busy           (busy),
    .devid_err      (devid_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Register program after reset: [DEVID read], two config writes, then the six
  // data registers read in a loop.
  function automatic txn_t expected_txn(input int idx);
    int j;
    if (idx < CFG_BASE) return '{8'h00, 1'b1, 8'h00};
    j = idx - CFG_BASE;
    if (j == 0) return '{8'h31, 1'b0, 8'h08};
    if (j == 1) return '{8'h2D, 1'b0, 8'h08};
    return '{8'h32 + 8'((j - 2) % 6), 1'b1, 8'h00};
  endfunction

  // Model state
  int          prog_idx = 0;
  bit          outstanding = 0, dead = 0;
  txn_t        cur;
  bit          exp_cfg = 0, exp_devid_err = 0, exp_sv = 0;
  logic [15:0] ex = 0, ey = 0, ez = 0;
  logic [7:0]  bytes [6];
  int          cycle = 0, last_sv = -1, last_fin = 0;
  int          wr_count = 0, sv_count = 0;
  bit          periodic_on = 1, no_overrun = 1, b2b_on = 0;
  bit          rst_q = 1;

  // Slave state
  int          txn_len = 20;
  int          s_cnt = 0, ready_hold = 0;
  bit          s_busy = 0, hold_req = 0, first_set = 1;
  txn_t        s_txn;
  logic [7:0]  devid_val = 8'hE5;
  logic [7:0]  first_tbl [6] = '{8'h34, 8'h12, 8'hFF, 8'hFF, 8'h00, 8'h80};

  initial begin : monitor
    bit   was_reset;
    txn_t e;
    int   b;
    forever begin
      @(negedge clk);
      cycle++;
      was_reset = rst_q;
      exp_sv = 1'b0;
      // Events sampled by the DUT at the posedge just gone.
      if (was_reset) begin
        prog_idx = 0; outstanding = 0; dead = 0;
        exp_cfg = 0; exp_devid_err = 0;
        ex = 0; ey = 0; ez = 0; last_sv = -1;
        for (int i = 0; i < 6; i++) bytes[i] = 8'h00;
      end else if (i2c_finished && outstanding) begin
        outstanding = 0;
        last_fin = cycle;
        prog_idx++;
        if (!cur.rw && cur.addr == 8'h2D) exp_cfg = 1;
        if (cur.rw && cur.addr == 8'h00 && i2c_read_data != 8'hE5) begin
          exp_devid_err = 1; dead = 1;
        end
        if (cur.rw && cur.addr >= 8'h32) begin
          b = int'(cur.addr - 8'h32);
          bytes[b] = i2c_read_data;
          if (b == 5) begin
            exp_sv = 1;
            ex = {bytes[1], bytes[0]};
            ey = {bytes[3], bytes[2]};
            ez = {bytes[5], bytes[4]};
          end
        end
      end
      if (was_reset) begin
        check("reset_req", {i2c_start, i2c_reg_addr, i2c_r_w, i2c_write_data, overrun}, 0);
      end else if (i2c_start) begin
        check("start_while_outstanding_or_dead", {outstanding, dead}, 0);
        check("start_without_ready", i2c_ready, 1'b1);
        e = expected_txn(prog_idx);
        check("req_addr", i2c_reg_addr, e.addr);
        check("req_r_w", i2c_r_w, e.rw);
        if (!e.rw) check("req_write_data", i2c_write_data, e.data);
        if (!e.rw) wr_count++;
        if (b2b_on) check("back_to_back_gap_ok", (cycle - last_fin) <= 4, 1'b1);
        cur = {i2c_reg_addr, i2c_r_w, i2c_write_data};
        outstanding = 1;
      end
      if (sample_valid) begin
        sv_count++;
        if (periodic_on && last_sv >= 0) check("sv_period", cycle - last_sv, P);
        last_sv = cycle;
      end
      check("dev_addr", i2c_dev_addr, 7'h1D);
      check("busy", busy, outstanding);
      check("sample_valid", sample_valid, exp_sv);
      check("accel_xyz", {accel_x, accel_y, accel_z}, {ex, ey, ez});
      check("cfg_done", cfg_done, exp_cfg);
      check("devid_err", devid_err, exp_devid_err);
      if (outstanding) check("req_stable", {i2c_reg_addr, i2c_r_w, i2c_write_data}, cur);
      if (no_overrun) check("overrun_low", overrun, 1'b0);

      // Bus-model slave: drive inputs for the next posedge.
      i2c_finished  = 1'b0;
      i2c_read_data = 8'($urandom);
      if (was_reset) begin
        s_busy = 0; ready_hold = 0;
      end else if (i2c_start) begin
        s_busy = 1; s_cnt = txn_len;
        s_txn = {i2c_reg_addr, i2c_r_w, i2c_write_data};
      end else if (s_busy) begin
        s_cnt--;
        if (s_cnt == 0) begin
          s_busy = 0;
          i2c_finished = 1'b1;
          if (s_txn.rw && s_txn.addr == 8'h00) begin
            i2c_read_data = devid_val;
          end else if (s_txn.rw) begin
            b = int'(s_txn.addr - 8'h32);
            i2c_read_data = first_set ? first_tbl[b] : 8'($urandom);
            if (b == 5) first_set = 0;
            if (hold_req && b < 5) begin ready_hold = 50; hold_req = 0; end
          end
        end
      end else if (ready_hold > 0) begin
        ready_hold--;
      end else if ($urandom_range(0, 15) == 0) begin
        i2c_finished = 1'b1;  // stray pulse outside any transaction
      end
      i2c_ready = !s_busy && (ready_hold == 0);
      rst_q = rst;
    end
  end

  task automatic wait_sv(input int n, input int budget);
    int target = sv_count + n;
    int t = 0;
    while (sv_count < target && t < budget) begin
      @(posedge clk);
      t++;
    end
    check("sample_valid_within_budget", sv_count >= target, 1'b1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin : stimulus
    int wr_before;
    int t;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

`ifdef ACCEL_SEQ_DEVID_CHECK_EN
    devid_val = 8'hE4;
    repeat (300) @(posedge clk);
    check("devid_bad_err", devid_err, 1'b1);
    check("devid_bad_cfg_done", cfg_done, 1'b0);
    check("devid_bad_no_writes", wr_count, 0);
    devid_val = 8'hE5;
    pulse_reset();
`endif

    // Configuration then the fixed first sample set.
    wait_sv(1, 2000);
    check("first_x", accel_x, 16'h1234);
    check("first_y", accel_y, 16'hFFFF);
    check("first_z", accel_z, 16'h8000);
    check("cfg_write_count", wr_count, 2);
    check("cfg_done_lit", cfg_done, 1'b1);
    wait_sv(3, 2000);

    // Ready held low for 50 cycles in the middle of a read set.
    periodic_on = 0;
    hold_req = 1;
    wait_sv(2, 2000);
    check("hold_consumed", hold_req, 1'b0);
    last_sv = -1;
    periodic_on = 1;
    wait_sv(2, 2000);

    // Reset during the fourth read of a set.
    t = 0;
    while (!(outstanding && cur.addr == 8'h35) && t < 2000) begin
      @(posedge clk);
      t++;
    end
    check("found_fourth_read", outstanding && cur.addr == 8'h35, 1'b1);
    wr_before = wr_count;
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_accel", {accel_x, accel_y, accel_z}, 48'h0);
    check("rst_status", {i2c_start, busy, sample_valid, cfg_done, overrun}, 5'b0);
    check("rst_request", {i2c_reg_addr, i2c_r_w, i2c_write_data}, 17'h0);
    check("rst_dev_addr", i2c_dev_addr, 7'h1D);
    wait_sv(2, 3000);
    check("cfg_rewrites", wr_count - wr_before, 2);

    // Transactions longer than the poll period.
    periodic_on = 0;
    no_overrun = 0;
    txn_len = 1200;
    wait_sv(1, 20000);
    b2b_on = 1;
    wait_sv(1, 20000);
    check("overrun_set", overrun, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
